// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - pipeline and backing-memory signals of the data memory controller
interface data_mem_ctrl_if;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  func3;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        busy;
   logic        error;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   modport slave (
      input  mem_read, mem_write, func3, address, write_data, dmem_rdata, dmem_ack,
      output read_data, busy, error, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb
   );

   modport master (
      output mem_read, mem_write, func3, address, write_data, dmem_rdata, dmem_ack,
      input  read_data, busy, error, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - load/store controller between the MEM stage and a word-wide backing memory
module data_mem_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic           clk,
   input  logic           rst,
   data_mem_ctrl_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   // The counter holds k-1 during the k-th WAIT cycle, so the last permitted cycle is TIMEOUT_CYCLES-1.
   localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q;
   logic [1:0]  lane_q;
   logic [2:0]  func3_q;
   logic        write_q;
   logic [31:0] read_data_q;
   logic        error_q;
   logic        dmem_req_q;
   logic        dmem_we_q;
   logic [31:0] dmem_addr_q;
   logic [31:0] dmem_wdata_q;
   logic [3:0]  dmem_wstrb_q;

   logic        is_write, req_any, legal, aligned, req_ok, req_bad;
   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic        busy, start, fin_ack, fin_to, bad;

   always_comb begin
      is_write = bus.mem_write;
      req_any  = bus.mem_read | bus.mem_write;
      case (bus.func3)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = !is_write;
         default:                legal = 1'b0;
      endcase
      case (bus.func3[1:0])
         2'b01:   aligned = !bus.address[0];
         2'b10:   aligned = (bus.address[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
      req_ok  = req_any & legal & aligned;
      req_bad = req_any & !(legal & aligned);
   end

   always_comb begin
      st_wdata = bus.write_data;
      st_wstrb = 4'b1111;
      case (bus.func3[1:0])
         2'b00: begin
            st_wdata = {4{bus.write_data[7:0]}};
            st_wstrb = 4'b0001 << bus.address[1:0];
         end
         2'b01: begin
            st_wdata = {2{bus.write_data[15:0]}};
            st_wstrb = 4'b0011 << {bus.address[1], 1'b0};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = bus.dmem_rdata[{lane_q, 3'b000} +: 8];
      ld_half = bus.dmem_rdata[{lane_q[1], 4'b0000} +: 16];
      case (func3_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'b0, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'b0, ld_half};
         default: ld_data = bus.dmem_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      start   = 1'b0;
      fin_ack = 1'b0;
      fin_to  = 1'b0;
      bad     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_ok) begin
               busy    = 1'b1;
               start   = 1'b1;
               state_d = S_WAIT;
            end else begin
               bad = req_bad;
            end
         end
         S_WAIT: begin
            busy = 1'b1;
            // An acknowledge in the final permitted cycle still counts as success.
            if (bus.dmem_ack) begin
               fin_ack = 1'b1;
               state_d = S_DONE;
            end else if (cnt_q == LAST_WAIT) begin
               fin_to  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         lane_q       <= '0;
         func3_q      <= '0;
         write_q      <= 1'b0;
         read_data_q  <= '0;
         error_q      <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         dmem_wstrb_q <= '0;
      end else begin
         state_q <= state_d;
         error_q <= bad | fin_to;
         if (start) begin
            cnt_q        <= '0;
            lane_q       <= bus.address[1:0];
            func3_q      <= bus.func3;
            write_q      <= is_write;
            dmem_req_q   <= 1'b1;
            dmem_we_q    <= is_write;
            dmem_addr_q  <= {bus.address[31:2], 2'b00};
            dmem_wdata_q <= is_write ? st_wdata : 32'b0;
            dmem_wstrb_q <= is_write ? st_wstrb : 4'b0;
         end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q + 16'd1;
         end
         if (fin_ack || fin_to) begin
            dmem_req_q <= 1'b0;
         end
         if (fin_ack && !write_q) begin
            read_data_q <= ld_data;
         end else if (fin_to && !write_q) begin
            read_data_q <= '0;
         end
      end
   end

   assign bus.read_data  = read_data_q;
   assign bus.busy       = busy;
   assign bus.error      = error_q;
   assign bus.dmem_req   = dmem_req_q;
   assign bus.dmem_we    = dmem_we_q;
   assign bus.dmem_addr  = dmem_addr_q;
   assign bus.dmem_wdata = dmem_wdata_q;
   assign bus.dmem_wstrb = dmem_wstrb_q;
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum WAIT cycles without MEM_ACK before abort (1..65535).
REQ-002 SHALL have port CLK  in  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port MEM_READ  in  1  load request from the MEM stage.
REQ-005 SHALL have port MEM_WRITE  in  1  store request from the MEM stage.
REQ-006 SHALL have port FUNC3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 SHALL have port ADDRESS  in  32  byte address.
REQ-008 SHALL have port WRITE_DATA  in  32  store data, right-aligned.
REQ-009 SHALL have port READ_DATA  out  32  formatted load result.
REQ-010 SHALL have port BUSY  out  1  pipeline stall request.
REQ-011 SHALL have port ERROR  out  1  one-cycle fault pulse.
REQ-012 SHALL have port DMEM_REQ  out  1  backing-memory request.
REQ-013 SHALL have port DMEM_WE  out  1  1 = write access.
REQ-014 SHALL have port DMEM_ADDR  out  32  word address, bits [1:0] = 00.
REQ-015 SHALL have port DMEM_WDATA  out  32  lane-replicated store data.
REQ-016 SHALL have port DMEM_WSTRB  out  4  byte-lane write enables.
REQ-017 SHALL have port DMEM_RDATA  in  32  backing-memory read word.
REQ-018 SHALL have port DMEM_ACK  in  1  backing-memory completion, one cycle.

Function
REQ-019 SHALL implement states IDLE, WAIT, DONE.
REQ-020 IDLE: on valid request (MEM_READ or MEM_WRITE, aligned, legal FUNC3), SHALL capture ADDRESS, FUNC3, WRITE_DATA and type, then go to WAIT.
REQ-021 MEM_READ and MEM_WRITE both high SHALL be treated as a write.
REQ-022 BUSY SHALL be combinational: 1 in IDLE with a valid request, 1 in WAIT, 0 in DONE and otherwise.
REQ-023 DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_WSTRB SHALL be registered, held stable throughout WAIT, and DMEM_REQ SHALL be 0 outside WAIT.
REQ-024 WAIT: DMEM_ACK SHALL move to DONE next cycle; for loads, the formatted DMEM_RDATA is latched into READ_DATA on the same edge.
REQ-025 DONE SHALL last exactly one cycle, then go to IDLE; the pipeline advances on the edge ending DONE, so a held request is not reissued.
REQ-026 READ_DATA SHALL hold its value until the next completed load.
REQ-027 Load format: byte = lane ADDRESS[1:0], half = lane ADDRESS[1]; 000/001 sign-extend, 100/101 zero-extend, 010 full word.
REQ-028 Store strobes: SB 0001<<ADDRESS[1:0], SH 0011<<(2*ADDRESS[1]), SW 1111; WDATA = byte x4, half x2, or word.
REQ-029 Misaligned access (H with ADDRESS[0]=1, W with ADDRESS[1:0]!=0), or illegal FUNC3 (loads 011/110/111; stores other than 000/001/010), SHALL NOT issue DMEM_REQ; pulse ERROR the next cycle, BUSY stays 0, READ_DATA unchanged.
REQ-030 WAIT counter starts at 0 on entry; if it reaches TIMEOUT_CYCLES without ACK, SHALL drop DMEM_REQ, pulse ERROR, write READ_DATA=0 for loads, and go to DONE.
REQ-031 DMEM_ACK outside WAIT SHALL be ignored.
REQ-032 ACK in the same cycle the counter reaches TIMEOUT_CYCLES: ACK wins, no ERROR.

Reset
REQ-033 RST SHALL force IDLE, counter 0, READ_DATA 0, ERROR 0, DMEM_REQ 0, DMEM_WE 0, DMEM_ADDR 0, DMEM_WDATA 0, DMEM_WSTRB 0 on the next edge, in any state.
REQ-034 RST asserted in WAIT SHALL abandon the access without ERROR; a later stray ACK is ignored (REQ-031).

Verification
REQ-035 LB at 0x103, DMEM_RDATA=0x80AB_CDEF, ACK after 3 cycles -> DMEM_ADDR=0x100, READ_DATA=0xFFFF_FF80, BUSY high 4 cycles.
REQ-036 LHU at 0x102, RDATA=0x8001_1234 -> READ_DATA=0x0000_8001; LW at 0x104 -> full word returned.
REQ-037 SB at 0x201, WRITE_DATA=0x0000_00A5 -> DMEM_WSTRB=0010, DMEM_WDATA=0xA5A5_A5A5, DMEM_WE=1; SH at 0x202 -> WSTRB=1100.
REQ-038 LW at 0x102 -> no DMEM_REQ, ERROR pulses one cycle, BUSY never high.
REQ-039 TIMEOUT_CYCLES=4, no ACK -> DMEM_REQ drops after 4 WAIT cycles, ERROR pulse, READ_DATA=0; ACK on cycle 4 -> normal completion, no ERROR.
REQ-040 RST during WAIT, then ACK two cycles later -> IDLE, outputs at reset values, ACK ignored, next load completes normally.
